// File: rtl/ula_c_pipe.sv
// ula_c_pipe -- two-stage immediate/lane-insert ALU slice with valid/ready
// handshaking on both sides.
//
// Operations (formato):
//   00  pass dado
//   01  pass constante
//   10  sign-extend constante[LANE_BITS-1:0] to the full word
//   11  replace lane 'lane' of dado with constante[LANE_BITS-1:0];
//       a lane index past the last lane returns dado unchanged with err=1
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operation offered
//   in_ready   operation accepted when in_valid && in_ready
//   dado       register operand
//   constante  immediate operand
//   formato    operation select
//   lane       target lane for insert
//   out_valid  result valid
//   out_ready  result consumed when out_valid && out_ready
//   resultOP   result word
//   zero/neg/err  result flags, qualified by out_valid
//
// Pipeline: stage 1 captures the accepted operands; stage 2 computes and
// registers the result and flags. Stage 2 holds while out_ready is low.
module ula_c_pipe #(
  parameter int BITS_PALAVRA = 16,
  parameter int LANE_BITS    = 8,
  localparam int LANES = BITS_PALAVRA / LANE_BITS,
  localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [BITS_PALAVRA-1:0] dado,
  input  logic [BITS_PALAVRA-1:0] constante,
  input  logic [1:0]              formato,
  input  logic [LW-1:0]           lane,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [BITS_PALAVRA-1:0] resultOP,
  output logic                    zero,
  output logic                    neg,
  output logic                    err
);

  localparam int W = BITS_PALAVRA;
  // Lane count widened by one bit so the range check can see indices
  // equal to LANES when LANES is not a power of two (or is 1).
  localparam logic [LW:0] LANES_W = LANES[LW:0];

  logic          vld_p1;
  logic [W-1:0]  dado_p1;
  logic [W-1:0]  const_p1;
  logic [1:0]    fmt_p1;
  logic [LW-1:0] lane_p1;

  logic          vld_p2;
  logic          adv_p2;
  logic          accept;

  logic [W-1:0]  res_c;
  logic          err_c;

  function automatic logic [W-1:0] sext_lane(input logic [W-1:0] c);
    logic signed [W-1:0] r;
    for (int i = 0; i < W; i++) begin
      r[i] = (i < LANE_BITS) ? c[i] : c[LANE_BITS-1];
    end
    return r;
  endfunction

  function automatic logic lane_out_of_range(input logic [LW-1:0] l);
    return ({1'b0, l} >= LANES_W);
  endfunction

  function automatic logic [W-1:0] insert_lane(input logic [W-1:0] d,
                                               input logic [W-1:0] c,
                                               input logic [LW-1:0] l);
    logic [W-1:0] r;
    r = d;
    for (int i = 0; i < LANES; i++) begin
      if (l == LW'(i)) begin
        r[i*LANE_BITS +: LANE_BITS] = c[LANE_BITS-1:0];
      end
    end
    return r;
  endfunction

  // Stage 2 may load when it is empty or its result is being taken;
  // stage 1 advances on that same condition, so in_ready depends only on
  // pipeline state and out_ready, never on in_valid.
  assign adv_p2   = !vld_p2 || out_ready;
  assign in_ready = !vld_p1 || adv_p2;
  assign accept   = in_valid && in_ready;
  assign out_valid = vld_p2;

  // ---- stage 1: operand capture ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
    end else if (in_ready) begin
      vld_p1 <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      dado_p1  <= dado;
      const_p1 <= constante;
      fmt_p1   <= formato;
      lane_p1  <= lane;
    end
  end

  always_comb begin
    res_c = dado_p1;
    err_c = 1'b0;
    case (fmt_p1)
      2'b00: res_c = dado_p1;
      2'b01: res_c = const_p1;
      2'b10: res_c = sext_lane(const_p1);
      2'b11: begin
        if (lane_out_of_range(lane_p1)) begin
          res_c = dado_p1;
          err_c = 1'b1;
        end else begin
          res_c = insert_lane(dado_p1, const_p1, lane_p1);
        end
      end
      default: res_c = dado_p1;
    endcase
  end

  // ---- stage 2: result register ----
  // A bubble from stage 1 clears out_valid but leaves the last result in
  // place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2   <= 1'b0;
      resultOP <= '0;
      zero     <= 1'b0;
      neg      <= 1'b0;
      err      <= 1'b0;
    end else if (adv_p2) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        resultOP <= res_c;
        zero     <= (res_c == '0);
        neg      <= res_c[W-1];
        err      <= err_c;
      end
    end
  end

endmodule

// File: tb/tb_ula_c_pipe.sv
module tb_ula_c_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // default instance: 16-bit word, 8-bit lanes
  logic        in_valid, in_ready, out_valid, out_ready, zero, neg, err;
  logic [15:0] dado, constante, resultOP;
  logic [1:0]  formato;
  logic [0:0]  lane;

  // 32-bit word, 8-bit lanes
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_zero, b_neg, b_err;
  logic [31:0] b_dado, b_const, b_res;
  logic [1:0]  b_fmt;
  logic [1:0]  b_lane;

  // 16-bit word, single 16-bit lane: lane index 1 is out of range
  logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_zero, c_neg, c_err;
  logic [15:0] c_dado, c_const, c_res;
  logic [1:0]  c_fmt;
  logic [0:0]  c_lane;

  ula_c_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .dado(dado), .constante(constante), .formato(formato), .lane(lane),
    .out_valid(out_valid), .out_ready(out_ready), .resultOP(resultOP),
    .zero(zero), .neg(neg), .err(err));

  ula_c_pipe #(.BITS_PALAVRA(32), .LANE_BITS(8)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .dado(b_dado), .constante(b_const), .formato(b_fmt), .lane(b_lane),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .resultOP(b_res),
    .zero(b_zero), .neg(b_neg), .err(b_err));

  ula_c_pipe #(.BITS_PALAVRA(16), .LANE_BITS(16)) dut1l (
    .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .dado(c_dado), .constante(c_const), .formato(c_fmt), .lane(c_lane),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .resultOP(c_res),
    .zero(c_zero), .neg(c_neg), .err(c_err));

  typedef struct packed {
    logic [15:0] res;
    logic        e;
  } exp_t;

  typedef struct {
    logic [1:0]  fmt;
    logic [15:0] d;
    logic [15:0] c;
    logic [0:0]  l;
    logic [15:0] res;
    logic        e;
  } vec_t;

  exp_t sb[$];
  vec_t vt[10];

  int nvec = 0;
  int nerr = 0;
  int inflight = 0;
  logic hold_v = 1'b0;
  logic [15:0] hold_r = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    nvec++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t model16(input logic [1:0] f, input logic [15:0] d,
                                   input logic [15:0] c, input logic [0:0] l);
    exp_t r;
    r.e = 1'b0;
    case (f)
      2'b00: r.res = d;
      2'b01: r.res = c;
      2'b10: r.res = {{8{c[7]}}, c[7:0]};
      default: r.res = l[0] ? {c[7:0], d[7:0]} : {d[15:8], c[7:0]};
    endcase
    return r;
  endfunction

  // Scoreboard / protocol monitor for the default instance.
  always @(negedge clk) begin
    if (rst_n) begin
      check("in_ready_vs_occupancy", 64'(in_ready), 64'((inflight < 2) || out_ready));
      if (hold_v) begin
        check("stall_out_valid", 64'(out_valid), 64'd1);
        check("stall_resultOP", 64'(resultOP), 64'(hold_r));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_output", 64'(resultOP), 64'hDEAD_0000_0000_0000);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("resultOP", 64'(resultOP), 64'(e.res));
          check("zero", 64'(zero), 64'(e.res == 16'h0));
          check("neg", 64'(neg), 64'(e.res[15]));
          check("err", 64'(err), 64'(e.e));
        end
        inflight--;
      end
      if (in_valid && in_ready) inflight++;
      hold_v = out_valid && !out_ready;
      hold_r = resultOP;
    end
  end

  task automatic drive(input logic [1:0] f, input logic [15:0] d, input logic [15:0] c,
                       input logic [0:0] l, input exp_t e);
    int n;
    bit done;
    in_valid = 1'b1; formato = f; dado = d; constante = c; lane = l;
    n = 0; done = 0;
    while (!done) begin
      @(negedge clk);
      if (in_ready) done = 1;
      else begin
        n++;
        if (n > 100) begin
          check("accept_timeout", 64'd0, 64'd1);
          done = 1;
        end
      end
    end
    sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_remaining", 64'(sb.size()), 64'd0);
  endtask

  task automatic run_b(input logic [1:0] f, input logic [31:0] d, input logic [31:0] c,
                       input logic [1:0] l, input logic [31:0] want, input logic we);
    int n;
    b_in_valid = 1'b1; b_fmt = f; b_dado = d; b_const = c; b_lane = l;
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    n = 0;
    while (!b_out_valid && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    check("w32_out_valid", 64'(b_out_valid), 64'd1);
    check("w32_resultOP", 64'(b_res), 64'(want));
    check("w32_flags", {61'd0, b_zero, b_neg, b_err}, {61'd0, want == 32'h0, want[31], we});
  endtask

  task automatic run_c(input logic [1:0] f, input logic [15:0] d, input logic [15:0] c,
                       input logic [0:0] l, input logic [15:0] want, input logic we);
    int n;
    c_in_valid = 1'b1; c_fmt = f; c_dado = d; c_const = c; c_lane = l;
    @(posedge clk); #1;
    c_in_valid = 1'b0;
    n = 0;
    while (!c_out_valid && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    check("l1_out_valid", 64'(c_out_valid), 64'd1);
    check("l1_resultOP", 64'(c_res), 64'(want));
    check("l1_flags", {61'd0, c_zero, c_neg, c_err}, {61'd0, want == 16'h0, want[15], we});
  endtask

  initial begin
    vt[0] = '{2'b00, 16'h1234, 16'hFFFF, 1'b0, 16'h1234, 1'b0};
    vt[1] = '{2'b01, 16'h1234, 16'h8001, 1'b0, 16'h8001, 1'b0};
    vt[2] = '{2'b10, 16'h0000, 16'h0080, 1'b0, 16'hFF80, 1'b0};
    vt[3] = '{2'b10, 16'hFFFF, 16'h007F, 1'b0, 16'h007F, 1'b0};
    vt[4] = '{2'b00, 16'h0000, 16'h5555, 1'b0, 16'h0000, 1'b0};
    vt[5] = '{2'b11, 16'h00FF, 16'h1200, 1'b0, 16'h0000, 1'b0};
    vt[6] = '{2'b10, 16'h0000, 16'h01FF, 1'b0, 16'hFFFF, 1'b0};
    vt[7] = '{2'b01, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
    vt[8] = '{2'b11, 16'h1234, 16'h00AB, 1'b0, 16'h12AB, 1'b0};
    vt[9] = '{2'b11, 16'h1234, 16'h00AB, 1'b1, 16'hAB34, 1'b0};

    in_valid = 0; out_ready = 1; dado = '0; constante = '0; formato = '0; lane = '0;
    b_in_valid = 0; b_out_ready = 1; b_dado = '0; b_const = '0; b_fmt = '0; b_lane = '0;
    c_in_valid = 0; c_out_ready = 1; c_dado = '0; c_const = '0; c_fmt = '0; c_lane = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_resultOP", 64'(resultOP), 64'd0);
    check("reset_flags", {61'd0, zero, neg, err}, 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("in_ready_after_reset", 64'(in_ready), 64'd1);

    // latency: result visible in the second cycle after presentation
    drive(2'b00, 16'hC0DE, 16'h0000, 1'b0, '{16'hC0DE, 1'b0});
    check("latency_not_early", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    check("latency_out_valid", 64'(out_valid), 64'd1);
    wait_drain();

    // table vectors, back-to-back
    for (int i = 0; i < 10; i++) begin
      drive(vt[i].fmt, vt[i].d, vt[i].c, vt[i].l, '{vt[i].res, vt[i].e});
    end
    wait_drain();
    repeat (2) @(posedge clk);
    #1;
    check("bubble_out_valid", 64'(out_valid), 64'd0);
    check("bubble_hold_resultOP", 64'(resultOP), 64'hAB34);

    // four ops back-to-back with a three-cycle output stall
    fork
      begin
        drive(2'b00, 16'h1111, 16'h0000, 1'b0, model16(2'b00, 16'h1111, 16'h0000, 1'b0));
        drive(2'b01, 16'h0000, 16'h2222, 1'b0, model16(2'b01, 16'h0000, 16'h2222, 1'b0));
        drive(2'b10, 16'h0000, 16'h0093, 1'b0, model16(2'b10, 16'h0000, 16'h0093, 1'b0));
        drive(2'b11, 16'h4455, 16'h0066, 1'b1, model16(2'b11, 16'h4455, 16'h0066, 1'b1));
      end
      begin
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("full_in_ready_low", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    wait_drain();

    // random stream with random backpressure
    fork
      begin
        for (int k = 0; k < 24; k++) begin
          logic [1:0]  f;
          logic [15:0] d, c;
          logic [0:0]  l;
          f = 2'($urandom_range(0, 3));
          d = 16'($urandom);
          c = 16'($urandom);
          l = 1'($urandom_range(0, 1));
          drive(f, d, c, l, model16(f, d, c, l));
        end
      end
      begin
        repeat (60) begin
          @(posedge clk);
          #1 out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
      end
    join
    wait_drain();

    // reset with two operations in flight
    out_ready = 1'b0;
    drive(2'b10, 16'h0000, 16'h0080, 1'b0, '{16'hFF80, 1'b0});
    drive(2'b00, 16'h7777, 16'h0000, 1'b0, '{16'h7777, 1'b0});
    #3 rst_n = 1'b0;
    #1;
    check("async_reset_out_valid", 64'(out_valid), 64'd0);
    check("async_reset_resultOP", 64'(resultOP), 64'd0);
    check("async_reset_flags", {61'd0, zero, neg, err}, 64'd0);
    sb.delete();
    inflight = 0;
    hold_v = 1'b0;
    out_ready = 1'b1;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("in_ready_after_midrun_reset", 64'(in_ready), 64'd1);
    for (int k = 0; k < 4; k++) begin
      check("no_stale_output", 64'(out_valid), 64'd0);
      @(posedge clk); #1;
    end

    // 32-bit word
    run_b(2'b11, 32'h11223344, 32'h00000099, 2'd3, 32'h99223344, 1'b0);
    run_b(2'b11, 32'h11223344, 32'h000000EE, 2'd0, 32'h112233EE, 1'b0);
    run_b(2'b10, 32'h0, 32'h00000081, 2'd0, 32'hFFFFFF81, 1'b0);

    // single-lane word: lane 1 does not exist
    run_c(2'b11, 16'h0000, 16'hABCD, 1'b1, 16'h0000, 1'b1);
    run_c(2'b11, 16'h1234, 16'hABCD, 1'b1, 16'h1234, 1'b1);
    run_c(2'b11, 16'h1234, 16'hABCD, 1'b0, 16'hABCD, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
